// File: rtl/countdown_timer_if.sv
// Control and display bundle for countdown_timer. The master side drives the
// requests and preset; the slave side (the timer) drives the BCD count and status.
interface countdown_timer_if;
  logic       clr_flag;
  logic       load;
  logic [7:0] preset_sec;
  logic       start;
  logic       pause;
  logic [7:0] cnt_cs;
  logic [7:0] cnt_s;
  logic       borrow_1s;
  logic       running;
  logic       done;
  logic       alarm;
  logic [1:0] state_dbg;

  // Requests are level-sampled on every rising clk_100Hz edge; there is no
  // acknowledge, a request simply takes effect on the edge that sees it.
  modport master (
    output clr_flag, load, preset_sec, start, pause,
    input  cnt_cs, cnt_s, borrow_1s, running, done, alarm, state_dbg
  );

  modport slave (
    input  clr_flag, load, preset_sec, start, pause,
    output cnt_cs, cnt_s, borrow_1s, running, done, alarm, state_dbg
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD seconds.centiseconds countdown timer on the 100 Hz tick with a
// run/pause/done state machine and a timed alarm pulse on expiry.
module countdown_timer #(
  parameter int unsigned ALARM_CYCLES = 200
) (
  input  logic clk_100Hz,
  input  logic rst,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [9:0] ALARM_LOAD = 10'(ALARM_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cs_q, cs_d;
  logic [7:0] s_q, s_d;
  logic       alarm_q, alarm_d;
  logic [9:0] alarm_cnt_q, alarm_cnt_d;
  logic       count_zero;
  logic       preset_ok;

  assign count_zero = (cs_q == 8'h00) && (s_q == 8'h00);
  assign preset_ok  = (bus.preset_sec[7:4] <= 4'd5) && (bus.preset_sec[3:0] <= 4'd9);

  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cs_q        <= 8'h00;
      s_q         <= 8'h00;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= 10'd0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      s_q         <= s_d;
      alarm_q     <= alarm_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    s_d         = s_q;
    alarm_d     = alarm_q;
    alarm_cnt_d = alarm_cnt_q;

    // The alarm timer runs independently; clear and load override it below.
    if (alarm_q) begin
      if (alarm_cnt_q == 10'd0) alarm_d = 1'b0;
      else                      alarm_cnt_d = alarm_cnt_q - 10'd1;
    end

    if (bus.clr_flag) begin
      state_d     = IDLE;
      cs_d        = 8'h00;
      s_d         = 8'h00;
      alarm_d     = 1'b0;
      alarm_cnt_d = 10'd0;
    end else if (bus.load && (state_q != RUN)) begin
      state_d     = IDLE;
      cs_d        = 8'h00;
      s_d         = preset_ok ? bus.preset_sec : 8'h59;
      alarm_d     = 1'b0;
      alarm_cnt_d = 10'd0;
    end else if (bus.pause && (state_q == RUN)) begin
      state_d = PAUSE;
    end else if (bus.start && ((state_q == IDLE) || (state_q == PAUSE)) && !count_zero) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (cs_q == 8'h00) begin
        cs_d = 8'h99;
        if (s_q[3:0] == 4'd0) s_d = {s_q[7:4] - 4'd1, 4'd9};
        else                  s_d = {s_q[7:4], s_q[3:0] - 4'd1};
      end else if (cs_q[3:0] == 4'd0) begin
        cs_d = {cs_q[7:4] - 4'd1, 4'd9};
      end else begin
        cs_d = {cs_q[7:4], cs_q[3:0] - 4'd1};
      end
      // Last step 00.01 -> 00.00 lands in DONE with the alarm raised.
      if ((s_q == 8'h00) && (cs_q == 8'h01)) begin
        state_d     = DONE;
        alarm_d     = 1'b1;
        alarm_cnt_d = ALARM_LOAD;
      end
    end
  end

  assign bus.cnt_cs    = cs_q;
  assign bus.cnt_s     = s_q;
  assign bus.borrow_1s = (state_q == RUN) && (cs_q == 8'h00);
  assign bus.running   = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.alarm     = alarm_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer against a centisecond
// integer reference model.
module tb_countdown_timer;
  localparam int ALARM_CYCLES = 200;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk_100Hz = 1'b0;
  logic rst = 1'b0;
  countdown_timer_if bus ();

  countdown_timer #(.ALARM_CYCLES(ALARM_CYCLES)) dut (
    .clk_100Hz (clk_100Hz),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  int passed = 0;
  int total  = 0;

  // Reference model: remaining time as an integer number of centiseconds.
  int m_rem = 0;
  int m_st = M_IDLE;
  int m_alarm_left = 0;

  logic [19:0] exp_q[$];
  logic [19:0] obs_vec;
  assign obs_vec = {bus.cnt_s, bus.cnt_cs, bus.running, bus.done, bus.alarm, bus.borrow_1s};

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic [19:0] exp_vec();
    return {to_bcd(m_rem / 100), to_bcd(m_rem % 100), (m_st == M_RUN), (m_st == M_DONE),
            (m_alarm_left > 0), (m_st == M_RUN) && (m_rem % 100 == 0)};
  endfunction

  task automatic model_reset();
    m_rem = 0;
    m_st = M_IDLE;
    m_alarm_left = 0;
  endtask

  task automatic model_edge(input logic c, input logic l, input logic [7:0] p,
                            input logic st, input logic pa);
    int tens, units;
    if (m_alarm_left > 0) m_alarm_left--;
    tens  = int'(p[7:4]);
    units = int'(p[3:0]);
    if (c) begin
      model_reset();
    end else if (l && m_st != M_RUN) begin
      m_rem = (tens <= 5 && units <= 9) ? (tens * 10 + units) * 100 : 5900;
      m_st = M_IDLE;
      m_alarm_left = 0;
    end else if (pa && m_st == M_RUN) begin
      m_st = M_PAUSE;
    end else if (st && (m_st == M_IDLE || m_st == M_PAUSE) && m_rem != 0) begin
      m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      m_rem--;
      if (m_rem == 0) begin
        m_st = M_DONE;
        m_alarm_left = ALARM_CYCLES;
      end
    end
  endtask

  // Driver: hold inputs across one rising edge, advance the model, sample #1 later.
  task automatic step(input logic c, input logic l, input logic [7:0] p,
                      input logic st, input logic pa);
    bus.clr_flag = c;
    bus.load = l;
    bus.preset_sec = p;
    bus.start = st;
    bus.pause = pa;
    @(posedge clk_100Hz);
    model_edge(c, l, p, st, pa);
    #1;
    bus.clr_flag = 1'b0;
    bus.load = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic test_reset();
    bus.clr_flag = 0; bus.load = 0; bus.preset_sec = 8'h00; bus.start = 0; bus.pause = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk_100Hz);
    #1;
    model_reset();
    total++;
    if (obs_vec !== 20'h0) $display("FAIL reset_values got=%h want=%h", obs_vec, 20'h0);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    step(0, 1, 8'h02, 0, 0);
    total++;
    if ({bus.cnt_s, bus.cnt_cs, bus.running} !== {8'h02, 8'h00, 1'b0})
      $display("FAIL load_02 got=%h want=%h", {bus.cnt_s, bus.cnt_cs, bus.running}, {8'h02, 8'h00, 1'b0});
    else passed++;
    step(0, 0, 8'h00, 1, 0);
    total++;
    if (bus.running !== 1'b1) $display("FAIL start_running got=%b want=1", bus.running);
    else passed++;
    step(0, 0, 8'h00, 0, 0);
    total++;
    if ({bus.cnt_s, bus.cnt_cs, bus.borrow_1s} !== {8'h01, 8'h99, 1'b0})
      $display("FAIL first_decrement got=%h want=%h", {bus.cnt_s, bus.cnt_cs, bus.borrow_1s}, {8'h01, 8'h99, 1'b0});
    else passed++;
    for (int i = 0; i < 198; i++) begin
      step(0, 0, 8'h00, 0, 0);
      total++;
      if (obs_vec !== exp_vec()) $display("FAIL basic_count cyc=%0d got=%h want=%h", i, obs_vec, exp_vec());
      else passed++;
    end
    step(0, 0, 8'h00, 0, 0);
    total++;
    if ({bus.cnt_s, bus.cnt_cs, bus.done, bus.alarm, bus.running} !== {8'h00, 8'h00, 3'b110})
      $display("FAIL expiry got=%h want=%h", {bus.cnt_s, bus.cnt_cs, bus.done, bus.alarm, bus.running}, {8'h00, 8'h00, 3'b110});
    else passed++;
  endtask

  task automatic test_alarm();
    int hi_cnt = 0;
    for (int i = 0; i < 250; i++) begin
      step(0, 0, 8'h00, (i == 50 || i == 220), 0);
      if (bus.alarm === 1'b1) hi_cnt++;
      total++;
      if (obs_vec !== exp_vec()) $display("FAIL alarm_window cyc=%0d got=%h want=%h", i, obs_vec, exp_vec());
      else passed++;
    end
    total++;
    if (hi_cnt != ALARM_CYCLES - 1) $display("FAIL alarm_length got=%0d want=%0d", hi_cnt + 1, ALARM_CYCLES);
    else passed++;
    total++;
    if ({bus.done, bus.alarm, bus.cnt_s, bus.cnt_cs} !== {2'b10, 16'h0000})
      $display("FAIL done_holds got=%h want=%h", {bus.done, bus.alarm, bus.cnt_s, bus.cnt_cs}, {2'b10, 16'h0000});
    else passed++;
  endtask

  task automatic test_pause();
    step(0, 1, 8'h10, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    repeat (50) step(0, 0, 8'h00, 0, 0);
    total++;
    if ({bus.cnt_s, bus.cnt_cs} !== 16'h0950) $display("FAIL reach_0950 got=%h want=0950", {bus.cnt_s, bus.cnt_cs});
    else passed++;
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 30; i++) begin
      total++;
      if ({bus.cnt_s, bus.cnt_cs, bus.running} !== {16'h0950, 1'b0})
        $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, {bus.cnt_s, bus.cnt_cs, bus.running}, {16'h0950, 1'b0});
      else passed++;
      step(0, 0, 8'h00, 0, 0);
    end
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    total++;
    if ({bus.cnt_s, bus.cnt_cs, bus.running} !== {16'h0949, 1'b1})
      $display("FAIL resume got=%h want=%h", {bus.cnt_s, bus.cnt_cs, bus.running}, {16'h0949, 1'b1});
    else passed++;
    step(0, 0, 8'h00, 1, 1);
    total++;
    if ({bus.running, bus.state_dbg, bus.cnt_s, bus.cnt_cs} !== {1'b0, 2'd2, 16'h0949})
      $display("FAIL start_and_pause got=%h want=%h", {bus.running, bus.state_dbg, bus.cnt_s, bus.cnt_cs}, {1'b0, 2'd2, 16'h0949});
    else passed++;
  endtask

  task automatic test_invalid_load();
    logic [7:0] bad [2];
    bad[0] = 8'h7A;
    bad[1] = 8'h65;
    for (int i = 0; i < 2; i++) begin
      step(0, 1, bad[i], 0, 0);
      total++;
      if ({bus.cnt_s, bus.cnt_cs} !== 16'h5900) $display("FAIL invalid_preset in=%h got=%h want=5900", bad[i], {bus.cnt_s, bus.cnt_cs});
      else passed++;
    end
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    total++;
    if ({bus.running, bus.state_dbg, bus.cnt_s, bus.cnt_cs} !== {1'b0, 2'd0, 16'h0000})
      $display("FAIL start_at_zero got=%h want=%h", {bus.running, bus.state_dbg, bus.cnt_s, bus.cnt_cs}, {1'b0, 2'd0, 16'h0000});
    else passed++;
  endtask

  task automatic test_clear();
    step(0, 1, 8'h01, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    repeat (63) step(0, 0, 8'h00, 0, 0);
    total++;
    if ({bus.cnt_s, bus.cnt_cs} !== 16'h0037) $display("FAIL reach_0037 got=%h want=0037", {bus.cnt_s, bus.cnt_cs});
    else passed++;
    step(1, 0, 8'h00, 0, 0);
    total++;
    if ({bus.cnt_s, bus.cnt_cs, bus.state_dbg, bus.running} !== {16'h0000, 2'd0, 1'b0})
      $display("FAIL clear_mid_run got=%h want=%h", {bus.cnt_s, bus.cnt_cs, bus.state_dbg, bus.running}, {16'h0000, 2'd0, 1'b0});
    else passed++;
    step(0, 1, 8'h01, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    repeat (110) step(0, 0, 8'h00, 0, 0);
    total++;
    if (bus.alarm !== 1'b1) $display("FAIL alarm_before_clear got=%b want=1", bus.alarm);
    else passed++;
    step(1, 0, 8'h00, 0, 0);
    total++;
    if ({bus.alarm, bus.done} !== 2'b00) $display("FAIL clear_alarm got=%b want=00", {bus.alarm, bus.done});
    else passed++;
  endtask

  task automatic test_async_reset();
    step(0, 1, 8'h05, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    repeat (20) step(0, 0, 8'h00, 0, 0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    total++;
    if ({obs_vec, bus.state_dbg} !== 22'h0) $display("FAIL async_reset got=%h want=0", {obs_vec, bus.state_dbg});
    else passed++;
    #2 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 8'h00, 1, 0);
      total++;
      if (obs_vec !== 20'h0) $display("FAIL post_reset_idle cyc=%0d got=%h want=0", i, obs_vec);
      else passed++;
    end
    step(0, 1, 8'h03, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    total++;
    if ({bus.cnt_s, bus.cnt_cs, bus.running} !== {16'h0299, 1'b1})
      $display("FAIL restart_after_reset got=%h want=%h", {bus.cnt_s, bus.cnt_cs, bus.running}, {16'h0299, 1'b1});
    else passed++;
  endtask

  task automatic test_random();
    logic [19:0] e;
    logic c, l, st, pa;
    logic [7:0] p;
    for (int i = 0; i < 4000; i++) begin
      c  = ($urandom_range(0, 299) == 0);
      l  = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 7) == 0);
      pa = ($urandom_range(0, 24) == 0);
      p  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255));
      step(c, l, p, st, pa);
      exp_q.push_back(exp_vec());
      e = exp_q.pop_front();
      total++;
      if (obs_vec !== e) $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alarm();
    test_pause();
    test_invalid_load();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- BCD countdown timer at 100 Hz. It counts down from a preset seconds value to 00.00 in centisecond steps.
- It is the down-counting counterpart of the stopwatch's up-counting centisecond/second chain. It reuses the same BCD display format, so the digital clock's display mux drives it unchanged.
- Adds a run/pause/done state machine and a timed alarm output for the buzzer/LED logic.

Parameters:
- ALARM_CYCLES, 200, number of clk_100Hz cycles alarm stays high after expiry (200 = 2 s); legal range 1..1023.

Ports:
- clk_100Hz  input  1  100 Hz system tick clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset; forces every register to its reset value immediately.
- clr_flag  input  1  synchronous clear; count to 00.00, state to IDLE, alarm off.
- load  input  1  synchronous load of preset_sec; level-sampled each cycle.
- preset_sec  input  8  BCD seconds preset, [7:4] tens, [3:0] units.
- start  input  1  start/resume request, sampled each cycle.
- pause  input  1  pause request, sampled each cycle.
- cnt_cs  output  8  BCD centiseconds remaining, 00..99.
- cnt_s  output  8  BCD seconds remaining, 00..59.
- borrow_1s  output  1  combinational; high when state is RUN and cnt_cs == 8'h00 (seconds decrement on next edge).
- running  output  1  registered-state decode; high in RUN.
- done  output  1  high in DONE.
- alarm  output  1  registered; high for exactly ALARM_CYCLES cycles after entering DONE.

Behaviour:
- Reset values: cnt_cs = 8'h00, cnt_s = 8'h00, state IDLE, running = 0, done = 0, alarm = 0, alarm counter = 0.
- Reset takes effect immediately regardless of clock, including mid-RUN and mid-alarm.
- States: IDLE, RUN, PAUSE, DONE.
- Priority per edge: clr_flag > load > pause > start > counting.
- clr_flag (any state):
  - cnt_cs = 00, cnt_s = 00, state IDLE, alarm = 0, alarm counter = 0.
- load:
  - Accepted in IDLE, PAUSE, DONE; ignored in RUN.
  - On accept: cnt_s = preset_sec, cnt_cs = 00, state IDLE, alarm = 0.
  - Invalid preset (either nibble > 9, or value > 8'h59) loads 8'h59 instead.
- pause:
  - In RUN, moves to PAUSE; the count does not change on that edge.
  - Ignored in other states.
  - start and pause asserted together in RUN: pause wins.
- start:
  - In IDLE or PAUSE, moves to RUN if the count is not 00.00; the first decrement happens on the following edge.
  - With count 00.00: ignored, state unchanged.
  - Ignored in RUN and DONE; DONE is left only via load, clr_flag or rst.
- Counting (RUN only, one step per edge):
  - cnt_cs[3:0]: if 0 it becomes 9, else it decrements.
  - cnt_cs[7:4]: decrements only when cnt_cs[3:0] == 0; if 0 it becomes 9.
  - When cnt_cs == 00 (borrow_1s high): cnt_cs becomes 99 and cnt_s decrements in BCD (units 0→9 with tens decrement; tens never wrap because RUN is never entered at 00.00).
- Expiry:
  - On the edge where the count goes 00.01 → 00.00, state moves to DONE and alarm rises on that same edge.
  - The alarm counter loads ALARM_CYCLES-1 and decrements each cycle; alarm falls when it reaches 0 (alarm high for exactly ALARM_CYCLES edges-worth).
  - The count holds at 00.00 in DONE.
  - load or clr_flag during the alarm kills it on that edge.
- Counts never leave the BCD range. No binary intermediate exceeds 4 bits per digit.
- Latency: outputs are registered except borrow_1s, which is a combinational decode of state and cnt_cs.

Test Plan:
- Reset then load with preset_sec = 8'h02 -> cnt_s = 02, cnt_cs = 00, IDLE. Pulse start -> running = 1. After 1 cycle: 01.99, borrow_1s = 0. After 200 cycles total: 00.00, done = 1, alarm = 1.
- Default ALARM_CYCLES = 200, expiry -> alarm high exactly 200 cycles then low; done stays 1; a start during DONE -> no change.
- Preset 8'h10 running; pause when count = 09.50 -> holds 09.50 for 30 cycles. Restart -> next cycle 09.49. Assert start and pause together during RUN -> enters PAUSE.
- Load 8'h7A and 8'h65 -> cnt_s = 59 both times. Load 8'h00 then start -> remains IDLE, running = 0.
- clr_flag asserted mid-RUN at 00.37 -> next edge 00.00, IDLE. clr_flag during alarm -> alarm = 0 next edge.
- Assert rst asynchronously mid-RUN (between clock edges) -> all outputs zero immediately. After rst deasserts, no counting until load and start.
